// File: rtl/enc_dec_pkg.sv
// Shared constants and types for the 8-to-3 encoder / 3-to-8 decoder family.
package enc_dec_pkg;
  localparam int CODE_W    = 3;
  localparam int LINES     = 8;
  localparam int ENC_IN_W  = LINES;
  localparam int ENC_OUT_W = CODE_W;
  localparam int CNT_W     = 8;
  localparam int STAT_W    = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hold_state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction
endpackage

// File: rtl/dec_3to8.sv
// Pure combinational code-to-one-hot decoder, one compare per output line.
module dec_3to8
  import enc_dec_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [LINES-1:0]  onehot_o
);
  for (genvar k = 0; k < LINES; k++) begin : g_line
    assign onehot_o[k] = (code_i == CODE_W'(k));
  end
endmodule

// File: rtl/dec_3to8_hold.sv
// Decoder that holds each accepted code on out_onehot for HOLD_CYCLES cycles,
// with a 1-entry skid buffer. Optional dec_count output under DEC_3TO8_HOLD_STATS_EN.
module dec_3to8_hold
  import enc_dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic [LINES-1:0]  out_onehot,
  output logic              out_valid,
  output logic              out_done
`ifdef DEC_3TO8_HOLD_STATS_EN
  ,
  output logic [STAT_W-1:0] dec_count
`endif
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  hold_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] buf_code_q, buf_code_d;
  logic              buf_full_q, buf_full_d;
  logic [LINES-1:0]  onehot_q, onehot_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic              accept;
  logic              last;
  logic              load;
  logic [CODE_W-1:0] load_code;
  logic [LINES-1:0]  load_oh;

  assign in_ready = (state_q == IDLE) | ~buf_full_q;
  assign accept   = in_valid & in_ready;
  assign last     = (state_q == HOLD) && (cnt_q == LAST);
  // The buffer only feeds the output when full; otherwise a load is from in_code.
  assign load_code = (state_q == HOLD && buf_full_q) ? buf_code_q : in_code;

  dec_3to8 u_dec (
    .code_i   (load_code),
    .onehot_o (load_oh)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_code_d = buf_code_q;
    buf_full_d = buf_full_q;
    onehot_d   = onehot_q;
    valid_d    = valid_q;
    load       = 1'b0;
    case (state_q)
      IDLE: load = accept;
      HOLD: begin
        if (!last) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (accept) begin
            buf_code_d = in_code;
            buf_full_d = 1'b1;
          end
        end else if (buf_full_q) begin
          load       = 1'b1;
          buf_full_d = 1'b0;
        end else if (accept) begin
          load = 1'b1;
        end else begin
          state_d  = IDLE;
          onehot_d = '0;
          valid_d  = 1'b0;
          cnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d  = HOLD;
      onehot_d = load_oh;
      valid_d  = 1'b1;
      cnt_d    = '0;
    end
    done_d = (state_d == HOLD) && (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      buf_code_q <= '0;
      buf_full_q <= 1'b0;
      onehot_q   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_code_q <= buf_code_d;
      buf_full_q <= buf_full_d;
      onehot_q   <= onehot_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  assign out_onehot = onehot_q;
  assign out_valid  = valid_q;
  assign out_done   = done_q;

`ifdef DEC_3TO8_HOLD_STATS_EN
  logic [STAT_W-1:0] dec_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    dec_count_q <= '0;
    else if (load) dec_count_q <= sat_inc(dec_count_q);
  end

  assign dec_count = dec_count_q;
`endif
endmodule

// File: tb/tb_dec_3to8_hold.sv
// Randomized bench for dec_3to8_hold: two instances (HOLD_CYCLES=4 and 1) against a FIFO-level model.
module tb_dec_3to8_hold;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = '0;
  logic       rdy4, ov4, od4, rdy1, ov1, od1;
  logic [7:0] oh4, oh1;
`ifdef DEC_3TO8_HOLD_STATS_EN
  logic [15:0] dc4, dc1;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dec_3to8_hold #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
    .in_ready(rdy4), .out_onehot(oh4), .out_valid(ov4), .out_done(od4)
`ifdef DEC_3TO8_HOLD_STATS_EN
    , .dec_count(dc4)
`endif
  );

  dec_3to8_hold #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
    .in_ready(rdy1), .out_onehot(oh1), .out_valid(ov1), .out_done(od1)
`ifdef DEC_3TO8_HOLD_STATS_EN
    , .dec_count(dc1)
`endif
  );

  // Model: a depth-1 waiting FIFO in front of an output slot with a remaining-hold count.
  int hold_len[2] = '{4, 1};
  int mact[2], mcode[2], mleft[2], pn[2], pc[2], mloads[2];
  bit macc[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mact[m] = 0; mcode[m] = 0; mleft[m] = 0; pn[m] = 0; pc[m] = 0; mloads[m] = 0;
    end
  endtask

  function automatic logic [7:0] exp_oh(input int m);
    logic [7:0] one;
    one = 8'd1;
    return mact[m] != 0 ? (one << mcode[m]) : 8'h00;
  endfunction

  function automatic bit exp_done(input int m);
    return mact[m] != 0 && mleft[m] == 1;
  endfunction

  function automatic bit exp_rdy(input int m);
    return pn[m] == 0;
  endfunction

  task automatic cycle(input bit v, input logic [2:0] c);
    in_valid = v;
    in_code  = c;
    for (int m = 0; m < 2; m++) macc[m] = v && (pn[m] == 0);
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (mact[m] != 0 && mleft[m] > 1) begin
        mleft[m]--;
        if (macc[m]) begin pn[m] = 1; pc[m] = int'(c); end
      end else begin
        if (macc[m]) begin pn[m] = 1; pc[m] = int'(c); end
        if (pn[m] != 0) begin
          mact[m] = 1; mcode[m] = pc[m]; mleft[m] = hold_len[m]; pn[m] = 0;
          if (mloads[m] < 65535) mloads[m]++;
        end else begin
          mact[m] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (oh4 !== 8'h00 || ov4 !== 1'b0 || od4 !== 1'b0) begin
      fails++; $display("FAIL reset_out got oh=%h v=%b d=%b want 00 0 0", oh4, ov4, od4);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (rdy4 !== 1'b1 || rdy1 !== 1'b1) begin
      fails++; $display("FAIL reset_ready got %b/%b want 1/1", rdy4, rdy1);
    end
  endtask

  task automatic test_single();
    cycle(1, 3'd5);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (oh4 !== 8'h20 || ov4 !== 1'b1 || od4 !== (k == 3)) begin
        fails++; $display("FAIL single_hold k=%0d got oh=%h v=%b d=%b want 20 1 %0d", k, oh4, ov4, od4, k == 3);
      end
      cycle(0, 3'd0);
    end
    checks++;
    if (oh4 !== 8'h00 || ov4 !== 1'b0 || od4 !== 1'b0) begin
      fails++; $display("FAIL single_end got oh=%h v=%b d=%b want 00 0 0", oh4, ov4, od4);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [3];
    int idx;
    bit saw_stall;
    seq[0] = 3'd3; seq[1] = 3'd6; seq[2] = 3'd2;
    idx = 0;
    saw_stall = 0;
    for (int t = 0; t < 20; t++) begin
      cycle(idx < 3, idx < 3 ? seq[idx] : 3'd0);
      if (macc[0] && idx < 3) idx++;
      if (idx == 2 && rdy4 === 1'b0) saw_stall = 1;
      checks++;
      if (oh4 !== exp_oh(0) || ov4 !== (mact[0] != 0) || od4 !== exp_done(0) || rdy4 !== exp_rdy(0)) begin
        fails++;
        $display("FAIL b2b t=%0d got oh=%h v=%b d=%b r=%b want %h %0d %0d %0d",
                 t, oh4, ov4, od4, rdy4, exp_oh(0), mact[0] != 0, exp_done(0), exp_rdy(0));
      end
    end
    checks++;
    if (!saw_stall || idx != 3) begin
      fails++; $display("FAIL b2b_stall got stall=%0d accepted=%0d want 1 3", saw_stall, idx);
    end
  endtask

  task automatic test_bypass();
    cycle(1, 3'd1);
    cycle(0, 3'd0);
    cycle(0, 3'd0);
    cycle(0, 3'd0);
    checks++;
    if (oh4 !== 8'h02 || od4 !== 1'b1 || rdy4 !== 1'b1) begin
      fails++; $display("FAIL bypass_last got oh=%h d=%b r=%b want 02 1 1", oh4, od4, rdy4);
    end
    cycle(1, 3'd7);
    checks++;
    if (oh4 !== 8'h80 || ov4 !== 1'b1 || od4 !== 1'b0 || rdy4 !== 1'b1) begin
      fails++; $display("FAIL bypass_next got oh=%h v=%b d=%b r=%b want 80 1 0 1", oh4, ov4, od4, rdy4);
    end
    for (int t = 0; t < 5; t++) begin
      cycle(0, 3'd0);
      checks++;
      if (oh4 !== exp_oh(0) || od4 !== exp_done(0) || rdy4 !== 1'b1) begin
        fails++; $display("FAIL bypass_tail t=%0d got oh=%h d=%b r=%b want %h %0d 1", t, oh4, od4, rdy4, exp_oh(0), exp_done(0));
      end
    end
  endtask

  task automatic test_hold1();
    logic [7:0] one;
    one = 8'd1;
    for (int t = 0; t < 10 && (mact[0] != 0 || mact[1] != 0); t++) cycle(0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 3'(i));
      checks++;
      if (oh1 !== (one << i) || ov1 !== 1'b1 || od1 !== 1'b1 || rdy1 !== 1'b1) begin
        fails++; $display("FAIL hold1_walk i=%0d got oh=%h v=%b d=%b r=%b want %h 1 1 1", i, oh1, ov1, od1, rdy1, one << i);
      end
    end
    cycle(0, 3'd0);
    checks++;
    if (oh1 !== 8'h00 || ov1 !== 1'b0 || od1 !== 1'b0) begin
      fails++; $display("FAIL hold1_end got oh=%h v=%b d=%b want 00 0 0", oh1, ov1, od1);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      cycle(($urandom_range(0, 99) < 60), 3'($urandom_range(0, 7)));
      checks++;
      if (oh4 !== exp_oh(0) || ov4 !== (mact[0] != 0) || od4 !== exp_done(0) || rdy4 !== exp_rdy(0)) begin
        fails++;
        $display("FAIL rand4 t=%0d got oh=%h v=%b d=%b r=%b want %h %0d %0d %0d",
                 t, oh4, ov4, od4, rdy4, exp_oh(0), mact[0] != 0, exp_done(0), exp_rdy(0));
      end
      checks++;
      if (oh1 !== exp_oh(1) || ov1 !== (mact[1] != 0) || od1 !== exp_done(1) || rdy1 !== exp_rdy(1)) begin
        fails++;
        $display("FAIL rand1 t=%0d got oh=%h v=%b d=%b r=%b want %h %0d %0d %0d",
                 t, oh1, ov1, od1, rdy1, exp_oh(1), mact[1] != 0, exp_done(1), exp_rdy(1));
      end
    end
  endtask

`ifdef DEC_3TO8_HOLD_STATS_EN
  task automatic test_stats();
    checks++;
    if (dc4 !== 16'(mloads[0]) || dc1 !== 16'(mloads[1])) begin
      fails++; $display("FAIL stats_pre got %0d/%0d want %0d/%0d", dc4, dc1, mloads[0], mloads[1]);
    end
    for (int t = 0; t < 65600; t++) cycle(1, 3'($urandom_range(0, 7)));
    checks++;
    if (dc1 !== 16'hFFFF) begin
      fails++; $display("FAIL stats_sat got %h want ffff", dc1);
    end
    checks++;
    if (dc4 !== 16'(mloads[0])) begin
      fails++; $display("FAIL stats_count got %0d want %0d", dc4, mloads[0]);
    end
  endtask
`endif

  task automatic test_reset_mid();
    for (int t = 0; t < 10 && (mact[0] != 0 || pn[0] != 0); t++) cycle(0, 3'd0);
    cycle(1, 3'd2);
    cycle(1, 3'd5);
    checks++;
    if (rdy4 !== 1'b0 || oh4 !== 8'h04) begin
      fails++; $display("FAIL rstmid_setup got r=%b oh=%h want 0 04", rdy4, oh4);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (oh4 !== 8'h00 || ov4 !== 1'b0 || od4 !== 1'b0 || oh1 !== 8'h00 || ov1 !== 1'b0) begin
      fails++; $display("FAIL rstmid_async got oh=%h v=%b d=%b oh1=%h v1=%b want all 0", oh4, ov4, od4, oh1, ov1);
    end
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      cycle(0, 3'd0);
      checks++;
      if (oh4 !== 8'h00 || ov4 !== 1'b0 || od4 !== 1'b0 || rdy4 !== 1'b1) begin
        fails++; $display("FAIL rstmid_stale t=%0d got oh=%h v=%b d=%b r=%b want 00 0 0 1", t, oh4, ov4, od4, rdy4);
      end
    end
`ifdef DEC_3TO8_HOLD_STATS_EN
    checks++;
    if (dc4 !== 16'h0000 || dc1 !== 16'h0000) begin
      fails++; $display("FAIL rstmid_count got %h/%h want 0000/0000", dc4, dc1);
    end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_bypass();
    test_hold1();
    test_random();
`ifdef DEC_3TO8_HOLD_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/dec_3to8_hold.md
DEC_3TO8_HOLD -- requirements
Module: dec_3to8_hold

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, giving the number of cycles each decoded line is held asserted (legal 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_code is valid.
REQ-005 SHALL have port in_code, input, 3 bits: binary index to decode (0..7), in the same encoding as the 8-to-3 priority encoder output.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts in_code this cycle.
REQ-007 SHALL have port out_onehot, output, 8 bits: registered one-hot decode; bit k set for code k.
REQ-008 SHALL have port out_valid, output, 1 bit: out_onehot carries an active code.
REQ-009 SHALL have port out_done, output, 1 bit: high on the last hold cycle of the current code.

Function
REQ-010 SHALL transfer a code when in_valid and in_ready are both high at a rising clk edge; in_code is ignored otherwise.
REQ-011 SHALL implement FSM states IDLE and HOLD, plus a 1-entry skid buffer (buf_code, buf_full) and an 8-bit hold counter.
REQ-012 In IDLE: in_ready=1; an accepted code moves the FSM to HOLD, sets out_onehot=1<<code, out_valid=1 and counter=0 on the same edge (1-cycle latency).
REQ-013 In HOLD: out_onehot stays constant for exactly HOLD_CYCLES cycles; counter increments each cycle; out_done=1 while counter==HOLD_CYCLES-1.
REQ-014 In HOLD: in_ready=~buf_full; an accepted code is stored in the buffer, except on the last hold cycle with the buffer empty, when it bypasses straight into the next hold.
REQ-015 At hold end with buf_full: load buf_code, clear buf_full, restart counter, stay in HOLD; no idle gap between codes.
REQ-016 At hold end with buffer empty and no bypass: go to IDLE with out_onehot=0, out_valid=0.
REQ-017 HOLD_CYCLES=1: out_done high every HOLD cycle; back-to-back codes each appear for exactly one cycle.
REQ-018 out_onehot SHALL never have more than one bit set; out_onehot==0 iff out_valid==0.
REQ-019 Codes SHALL leave the block in acceptance order; no code is dropped or duplicated.

Reset
REQ-020 On rst_n low, immediately and asynchronously: FSM=IDLE, out_onehot=0, out_valid=0, out_done=0, buf_full=0, counter=0; in_ready=1 once rst_n is high.
REQ-021 Reset asserted mid-hold SHALL discard both the active and the buffered code.

Configuration
REQ-022 Macro DEC_3TO8_HOLD_STATS_EN defined: add output dec_count, 16 bits: number of codes loaded into out_onehot, saturating at 0xFFFF, reset to 0.
REQ-023 Macro undefined: port dec_count and its counter are absent; all other behaviour is identical.

Structure
REQ-024 SHALL put the FSM state enum (IDLE, HOLD) and the constants CODE_W=3 and LINES=8 in shared package enc_dec_pkg, alongside the encoder's constants.
REQ-025 SHALL keep the pure code-to-one-hot function in combinational sub-module dec_3to8; the FSM, buffer and counter live in dec_3to8_hold.

Verification
REQ-026 Reset then a single code: in_code=5 accepted -> next cycle out_onehot=8'b0010_0000 for 4 cycles, out_done on the 4th, then out_onehot=0.
REQ-027 Back-to-back codes: 3 then 6 sent with in_valid held -> 6 is buffered and in_ready drops; 0x08 is held 4 cycles, then 0x40 for 4 cycles with no gap; a third code stalls until the buffer frees.
REQ-028 Bypass: code 1 is held, code 7 is presented only on the last hold cycle -> 0x80 follows 0x02 with no gap and buf_full stays 0.
REQ-029 HOLD_CYCLES=1 with a continuous stream 0..7 -> out_onehot walks 0x01..0x80, one cycle each, out_done always 1.
REQ-030 rst_n pulsed low mid-hold with the buffer full -> outputs clear asynchronously; after release, no stale code appears.
REQ-031 With DEC_3TO8_HOLD_STATS_EN: 70000 codes -> dec_count=0xFFFF; without the macro, the build has no dec_count port.
